msx_bus_initiator: RTL

- Bus-master engine that generates MSX cartridge-slot bus cycles: memory read/write and I/O read/write.
- It drives the same signals a cartridge-side mapper decodes: addr, merq_n, iorq_n, sltsl_n, rd_n, wr_n and data.
- Sits between internal logic (for example the cartridge dump/test engine) and the external slot connector.
- Handles one transaction at a time, with wait-state support and a timeout.

---
 rtl/msx_bus_initiator.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/msx_bus_initiator.sv
// MSX cartridge-slot bus master: issues one memory or I/O read/write cycle per request,
// with setup/strobe/hold timing, wait-state stretching and a wait timeout.
module msx_bus_initiator #(
  parameter int unsigned T_SETUP  = 1,
  parameter int unsigned T_STROBE = 2,
  parameter int unsigned T_HOLD   = 1,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_we,
  input  logic        req_io,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [7:0]  rdata,
  output logic [15:0] addr,
  output logic [7:0]  dout,
  output logic        dout_oe,
  input  logic [7:0]  din,
  output logic        sltsl_n,
  output logic        merq_n,
  output logic        iorq_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic        m1_n,
  input  logic        wait_n
);

  localparam int unsigned CntW  = 8;
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0]  CntOne  = CntW'(1);
  localparam logic [WaitW-1:0] WaitOne = WaitW'(1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSetup  = 3'd1;
  localparam logic [2:0] StStrobe = 3'd2;
  localparam logic [2:0] StHold   = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WaitW-1:0] wcnt_q, wcnt_d;
  logic             to_q, to_d;
  logic             we_q, we_d;
  logic             io_q, io_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       dout_q, dout_d;
  logic [7:0]       rdata_q, rdata_d;

  logic busy_q, ack_q, err_q, oe_q;
  logic sltsl_n_q, merq_n_q, iorq_n_q, rd_n_q, wr_n_q;
  logic busy_d, ack_d, err_d, oe_d;
  logic sltsl_n_d, merq_n_d, iorq_n_d, rd_n_d, wr_n_d;
  logic strobe_exit, active, strobing;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;
    to_d        = to_q;
    we_d        = we_q;
    io_d        = io_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    rdata_d     = rdata_q;
    strobe_exit = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (req) begin
          state_d = StSetup;
          cnt_d   = CntW'(T_SETUP);
          wcnt_d  = '0;
          to_d    = 1'b0;
          we_d    = req_we;
          io_d    = req_io;
          addr_d  = req_addr;
          if (req_we) dout_d = req_wdata;
        end
      end
      StSetup: begin
        if (cnt_q <= CntOne) begin
          state_d = StStrobe;
          cnt_d   = CntW'(T_STROBE);
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StStrobe: begin
        if (cnt_q > CntOne) begin
          cnt_d = cnt_q - CntOne;
        end else if (wait_n) begin
          strobe_exit = 1'b1;
        end else if (wcnt_q == WaitMax) begin
          strobe_exit = 1'b1;
          to_d        = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WaitOne;
        end
        if (strobe_exit) begin
          state_d = StHold;
          cnt_d   = CntW'(T_HOLD);
          // A timed-out cycle never produced valid data, so report the idle-bus value.
          if (to_d)       rdata_d = 8'hFF;
          else if (!we_q) rdata_d = din;
        end
      end
      StHold: begin
        if (cnt_q <= CntOne) state_d = StDone;
        else                 cnt_d   = cnt_q - CntOne;
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs are decoded from the next state so they come straight from flops.
  always_comb begin
    active    = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold);
    strobing  = (state_d == StStrobe);
    busy_d    = active;
    ack_d     = (state_d == StDone);
    err_d     = (state_d == StDone) && to_d;
    oe_d      = active && we_d;
    sltsl_n_d = !(active && !io_d);
    merq_n_d  = !(active && !io_d);
    iorq_n_d  = !(strobing && io_d);
    rd_n_d    = !(strobing && !we_d);
    wr_n_d    = !(strobing && we_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      to_q      <= 1'b0;
      we_q      <= 1'b0;
      io_q      <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
      rdata_q   <= 8'hFF;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      oe_q      <= 1'b0;
      sltsl_n_q <= 1'b1;
      merq_n_q  <= 1'b1;
      iorq_n_q  <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      to_q      <= to_d;
      we_q      <= we_d;
      io_q      <= io_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      oe_q      <= oe_d;
      sltsl_n_q <= sltsl_n_d;
      merq_n_q  <= merq_n_d;
      iorq_n_q  <= iorq_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
    end
  end

  assign busy    = busy_q;
  assign ack     = ack_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign addr    = addr_q;
  assign dout    = dout_q;
  assign dout_oe = oe_q;
  assign sltsl_n = sltsl_n_q;
  assign merq_n  = merq_n_q;
  assign iorq_n  = iorq_n_q;
  assign rd_n    = rd_n_q;
  assign wr_n    = wr_n_q;
  assign m1_n    = 1'b1;

endmodule
